// File: rtl/writeback_router.sv
// Writeback router: buffers ALU results in a small FIFO and steers
// the head entry to one of NUM_DEST consumers (GPR, RAM, PC, ...).
module writeback_router #(
   parameter int DATA_W   = 32,
   parameter int NUM_DEST = 3,
   parameter int DEPTH    = 4,
   localparam int DEST_W  = (NUM_DEST <= 2) ? 1 : $clog2(NUM_DEST),
   localparam int CNT_W   = $clog2(DEPTH) + 1
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DEST_W-1:0]          in_dest,
   input  logic [DATA_W-1:0]          in_data,
   input  logic                       flush,
   output logic [NUM_DEST-1:0]        out_valid,
   input  logic [NUM_DEST-1:0]        out_ready,
   output logic [NUM_DEST*DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]           level,
   output logic [7:0]                 err_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [DEST_W:0] NUM_DEST_L = (DEST_W+1)'(NUM_DEST);
   localparam logic [CNT_W-1:0] FULL_L = CNT_W'(DEPTH);

   logic [DEST_W-1:0] dest_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [DEST_W-1:0] head_dest;
   logic [DATA_W-1:0] head_data;
   logic [DEST_W-1:0] push_dest;
   logic              illegal;
   logic              not_empty;
   logic              head_taken;
   logic              push;
   logic              pop;

   assign not_empty = (level != '0);
   assign in_ready  = (level != FULL_L);
   assign illegal   = ({1'b0, in_dest} >= NUM_DEST_L);
   assign push_dest = illegal ? '0 : in_dest;
   assign head_dest = dest_mem[rd_ptr];
   assign head_data = data_mem[rd_ptr];

   // Outputs are gated by level so stale storage never leaks out.
   always_comb begin
      out_valid = '0;
      out_data  = '0;
      for (int d = 0; d < NUM_DEST; d++) begin
         if (not_empty && head_dest == DEST_W'(d)) begin
            out_valid[d] = 1'b1;
            out_data[d*DATA_W +: DATA_W] = head_data;
         end
      end
   end

   assign head_taken = |(out_valid & out_ready);
   assign push = in_valid && in_ready && !flush;
   assign pop  = head_taken && !flush;

   always_ff @(posedge clk) begin
      if (push) begin
         dest_mem[wr_ptr] <= push_dest;
         data_mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_cnt <= '0;
      end else if (push && illegal && err_cnt != 8'hFF) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule
